vreg_operand_collector: RTL
===========================

// Module: vreg_operand_collector
// PURPOSE
//  Requester side of the banked vector register file read interface.
//  - Accepts one instruction's operand specifiers: up to DREAD_PORTS vector sources and MREAD_PORTS mask sources.
//  - Drives the regfile's per-port read requests and re-requests until every operand returns; conflicts may spread returns over cycles.
//  - Delivers the assembled operand bundle to the vector execute stage over a valid/ready handshake.
// PARAMETERS
//  DREAD_PORTS  4    vector read ports driven
//  MREAD_PORTS  2    mask read ports driven
//  VLMAX        32   elements per vector
//  ELEM_W       16   bits per element (bf16)
//  VREG_IDX     8    vector register specifier width
//  MASK_IDX     4    mask register specifier width
//  TAG_W        6    opaque instruction tag width
//  STALL_MAX    64   no-progress cycles before timeout_err
// PORTS
//  CLK          in   1                          clock
//  RST          in   1                          synchronous active-high reset
//  issue_valid  in   1                          operand request valid
//  issue_ready  out  1                          collector can accept a request
//  issue_ren    in   DREAD_PORTS                vector source used, per port
//  issue_vs     in   DREAD_PORTS*VREG_IDX       vector source specifiers
//  issue_mren   in   MREAD_PORTS                mask source used, per port
//  issue_vms    in   MREAD_PORTS*MASK_IDX       mask source specifiers
//  issue_tag    in   TAG_W                      tag carried to output
//  rf_ren       out  DREAD_PORTS                regfile vector read enables
//  rf_vs        out  DREAD_PORTS*VREG_IDX       regfile vector read specifiers
//  rf_mren      out  MREAD_PORTS                regfile mask read enables
//  rf_vms       out  MREAD_PORTS*MASK_IDX       regfile mask read specifiers
//  rf_ready     in   1                          regfile not in conflict-resolution
//  rf_dvalid    in   DREAD_PORTS                vector data valid, per port
//  rf_vreg      in   DREAD_PORTS*VLMAX*ELEM_W   vector read data
//  rf_mvalid    in   MREAD_PORTS                mask data valid, per port
//  rf_vmask     in   MREAD_PORTS*VLMAX          mask read data
//  op_valid     out  1                          operand bundle valid
//  op_ready     in   1                          execute stage accepts bundle
//  op_vreg      out  DREAD_PORTS*VLMAX*ELEM_W   collected vector operands
//  op_vmask     out  MREAD_PORTS*VLMAX          collected mask operands
//  op_tag       out  TAG_W                      tag of the bundle
//  conflict_cyc out  16                         saturating count of COLLECT cycles with rf_ready=0
//  timeout_err  out  1                          sticky no-progress error
// BEHAVIOUR
//  Reset (RST high at posedge):
//  - State goes to IDLE; need/got masks, specifiers, data, tag, conflict_cyc and stall counter clear to 0.
//  - issue_ready=1; every other output is 0.
//  - Reset mid-operation discards the in-flight bundle with no output.
//  FSM:
//  - IDLE: issue_ready=1. On issue_valid, latch ren/mren as need masks, latch specifiers and tag, clear got and stall counter.
//    Next state is COLLECT, or HOLD if need is all-zero.
//  - COLLECT: rf_ren = need & ~got; rf_mren = mneed & ~mgot.
//    rf_vs/rf_vms always show the latched specifiers; they are 0 in IDLE.
//  - Capture: on rf_dvalid[p] & need[p] & ~got[p], register rf_vreg slice p and set got[p]; masks likewise.
//    Valids on unneeded or already-got ports are ignored, so captured data is never overwritten.
//    Several ports may capture in the same cycle.
//  - Leave COLLECT for HOLD when got|captures_this_cycle covers need and mneed.
//  - HOLD: op_valid=1, and op_* stay stable until op_ready.
//    On op_valid&op_ready go to IDLE, and op_* return to 0.
//    Operand slices of unused ports always read 0.
//  - issue_ready=0 in COLLECT and HOLD.
//  Latency, no conflicts: issue accepted in cycle T; data returns in T+1; op_valid=1 in T+2.
//  Each extra regfile conflict cycle adds one cycle.
//  Counters:
//  - Stall counter counts consecutive COLLECT cycles with no capture and resets on any capture.
//  - When the stall counter reaches STALL_MAX, timeout_err sets and stays set until RST; the FSM keeps waiting.
//  - conflict_cyc saturates at 16'hFFFF and is never cleared except by RST.
// TESTING
//  1. Reset: hold RST 2 cycles mid-COLLECT -> issue_ready=1, op_valid=0, rf_ren=0, conflict_cyc=0.
//  2. No conflict: issue ren=4'b0011, vs0=8'h04, vs1=8'h05, regfile returns dvalid=4'b0011 at T+1
//     -> op_valid at T+2, op_vreg slices 0/1 match, slices 2/3 are 0, op_tag matches.
//  3. Bank conflict: vs0=8'h04, vs1=8'h08 (same bank); returns port0 at T+1, port1 at T+2 with rf_ready=0
//     -> rf_ren 4'b0011 then 4'b0010, op_valid at T+3, conflict_cyc=1.
//  4. Zero-operand issue (ren=0, mren=0) -> op_valid=1 at T+1; hold op_ready=0 for 5 cycles -> op_* stable, issue_ready=0.
//  5. Spurious rf_dvalid=4'b1111 with need=4'b0001 -> only slice 0 captured; a second dvalid[0] after capture does not change op_vreg.
//  6. Withhold all returns for STALL_MAX cycles -> timeout_err=1 stays high; a late return still completes the bundle normally.

Source files
------------

// File: rtl/vreg_operand_collector.sv
// Operand collector for the banked vector register file: requests every source an
// instruction needs, captures returns as they trickle in, and hands off the bundle.
module vreg_operand_collector #(
  parameter int DREAD_PORTS = 4,
  parameter int MREAD_PORTS = 2,
  parameter int VLMAX       = 32,
  parameter int ELEM_W      = 16,
  parameter int VREG_IDX    = 8,
  parameter int MASK_IDX    = 4,
  parameter int TAG_W       = 6,
  parameter int STALL_MAX   = 64
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                issue_valid,
  output logic                                issue_ready,
  input  logic [DREAD_PORTS-1:0]              issue_ren,
  input  logic [DREAD_PORTS*VREG_IDX-1:0]     issue_vs,
  input  logic [MREAD_PORTS-1:0]              issue_mren,
  input  logic [MREAD_PORTS*MASK_IDX-1:0]     issue_vms,
  input  logic [TAG_W-1:0]                    issue_tag,
  output logic [DREAD_PORTS-1:0]              rf_ren,
  output logic [DREAD_PORTS*VREG_IDX-1:0]     rf_vs,
  output logic [MREAD_PORTS-1:0]              rf_mren,
  output logic [MREAD_PORTS*MASK_IDX-1:0]     rf_vms,
  input  logic                                rf_ready,
  input  logic [DREAD_PORTS-1:0]              rf_dvalid,
  input  logic [DREAD_PORTS*VLMAX*ELEM_W-1:0] rf_vreg,
  input  logic [MREAD_PORTS-1:0]              rf_mvalid,
  input  logic [MREAD_PORTS*VLMAX-1:0]        rf_vmask,
  output logic                                op_valid,
  input  logic                                op_ready,
  output logic [DREAD_PORTS*VLMAX*ELEM_W-1:0] op_vreg,
  output logic [MREAD_PORTS*VLMAX-1:0]        op_vmask,
  output logic [TAG_W-1:0]                    op_tag,
  output logic [15:0]                         conflict_cyc,
  output logic                                timeout_err
);
  localparam int VW = VLMAX * ELEM_W;
  localparam int SW = $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

  state_t                          r_state, w_state_nxt;
  logic [DREAD_PORTS-1:0]          r_need, r_got, w_cap;
  logic [MREAD_PORTS-1:0]          r_mneed, r_mgot, w_mcap;
  logic [DREAD_PORTS*VREG_IDX-1:0] r_vs;
  logic [MREAD_PORTS*MASK_IDX-1:0] r_vms;
  logic [TAG_W-1:0]                r_tag;
  logic [DREAD_PORTS*VW-1:0]       r_vreg;
  logic [MREAD_PORTS*VLMAX-1:0]    r_vmask;
  logic [15:0]                     r_conflict;
  logic [SW-1:0]                   r_stall, w_stall_inc;
  logic                            r_timeout;
  logic                            w_done;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [SW-1:0] sat_stall(input logic [SW-1:0] v);
    return (v == SW'(STALL_MAX)) ? v : v + SW'(1);
  endfunction

  // A valid only captures on a needed, not-yet-captured port, so held data is never overwritten
  assign w_cap       = (r_state == S_COLLECT) ? (rf_dvalid & r_need & ~r_got) : '0;
  assign w_mcap      = (r_state == S_COLLECT) ? (rf_mvalid & r_mneed & ~r_mgot) : '0;
  assign w_done      = ((r_got | w_cap) == r_need) && ((r_mgot | w_mcap) == r_mneed);
  assign w_stall_inc = sat_stall(r_stall);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (issue_valid)
                   w_state_nxt = ((issue_ren == '0) && (issue_mren == '0)) ? S_HOLD : S_COLLECT;
      S_COLLECT: if (w_done) w_state_nxt = S_HOLD;
      S_HOLD:    if (op_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_need     <= '0;
      r_got      <= '0;
      r_mneed    <= '0;
      r_mgot     <= '0;
      r_vs       <= '0;
      r_vms      <= '0;
      r_tag      <= '0;
      r_vreg     <= '0;
      r_vmask    <= '0;
      r_conflict <= '0;
      r_stall    <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (issue_valid) begin
          r_need  <= issue_ren;
          r_mneed <= issue_mren;
          r_got   <= '0;
          r_mgot  <= '0;
          r_vs    <= issue_vs;
          r_vms   <= issue_vms;
          r_tag   <= issue_tag;
          r_vreg  <= '0;
          r_vmask <= '0;
          r_stall <= '0;
        end
        S_COLLECT: begin
          r_got  <= r_got | w_cap;
          r_mgot <= r_mgot | w_mcap;
          for (int p = 0; p < DREAD_PORTS; p++)
            if (w_cap[p]) r_vreg[p*VW +: VW] <= rf_vreg[p*VW +: VW];
          for (int m = 0; m < MREAD_PORTS; m++)
            if (w_mcap[m]) r_vmask[m*VLMAX +: VLMAX] <= rf_vmask[m*VLMAX +: VLMAX];
          if (!rf_ready) r_conflict <= sat_inc16(r_conflict);
          // Timeout flags a stuck regfile but the collector keeps waiting for it
          if ((w_cap != '0) || (w_mcap != '0)) begin
            r_stall <= '0;
          end else begin
            r_stall <= w_stall_inc;
            if (w_stall_inc == SW'(STALL_MAX)) r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign issue_ready  = (r_state == S_IDLE);
  assign rf_ren       = (r_state == S_COLLECT) ? (r_need & ~r_got) : '0;
  assign rf_mren      = (r_state == S_COLLECT) ? (r_mneed & ~r_mgot) : '0;
  assign rf_vs        = (r_state != S_IDLE) ? r_vs : '0;
  assign rf_vms       = (r_state != S_IDLE) ? r_vms : '0;
  assign op_valid     = (r_state == S_HOLD);
  assign op_vreg      = op_valid ? r_vreg : '0;
  assign op_vmask     = op_valid ? r_vmask : '0;
  assign op_tag       = op_valid ? r_tag : '0;
  assign conflict_cyc = r_conflict;
  assign timeout_err  = r_timeout;
endmodule
